// File: rtl/pipeline_mem_ctrl_pkg.sv
// Shared types for the lc3b pipeline memory controller: FSM encodings,
// opcode enumeration and the load/store decode used to derive mem_access.
package pipeline_mem_ctrl_pkg;

   localparam int RETRY_MAX_DEF   = 15;
   localparam int STALL_CNT_W_DEF = 16;

   typedef enum logic {I_FETCH, I_HELD} lc3b_ifsm_t;
   typedef enum logic {D_IDLE, D_BACKOFF} lc3b_dfsm_t;

   typedef enum logic [3:0] {
      OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
      OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
      OP_RTI = 4'h8, OP_XOR = 4'h9, OP_LDI = 4'ha, OP_STI  = 4'hb,
      OP_JMP = 4'hc, OP_SHF = 4'hd, OP_LEA = 4'he, OP_TRAP = 4'hf
   } lc3b_opcode;

   // TRAP reads its vector from data memory, so it counts as a memory op.
   function automatic logic is_mem_op(lc3b_opcode op);
      case (op)
         OP_LDB, OP_STB, OP_LDR, OP_STR,
         OP_LDI, OP_STI, OP_TRAP: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_mem_ctrl_if.sv
// Wishbone-style strobe/response signals between the pipeline controller
// and the instruction/data caches.
interface pipeline_mem_ctrl_if;

   logic imem_stb;
   logic imem_cyc;
   logic imem_resp;
   logic dmem_stb;
   logic dmem_cyc;
   logic dmem_resp;
   logic dmem_retry;

   modport master (
      output imem_stb, imem_cyc, dmem_stb, dmem_cyc,
      input  imem_resp, dmem_resp, dmem_retry
   );

   modport slave (
      input  imem_stb, imem_cyc, dmem_stb, dmem_cyc,
      output imem_resp, dmem_resp, dmem_retry
   );

endinterface

// File: rtl/pipeline_mem_ctrl_dmem_port_fsm.sv
// D-cache port sequencer: issues the access, backs off one cycle on retry,
// abandons the access after RETRY_MAX retries and flags mem_err.
//   state     | meaning
//   D_IDLE    | strobe asserted while an unfinished access is in EX/MEM
//   D_BACKOFF | one-cycle gap after a retry, cycle held open
module pipeline_mem_ctrl_dmem_port_fsm
   import pipeline_mem_ctrl_pkg::*;
#(
   parameter int RETRY_MAX = RETRY_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic mem_access,
   input  logic dmem_resp,
   input  logic dmem_retry,
   input  logic advance,
   output logic dmem_stb,
   output logic dmem_cyc,
   output logic d_ready,
   output logic mem_err
);

   localparam int CNT_W = $clog2(RETRY_MAX + 1);

   lc3b_dfsm_t       d_state;
   logic [CNT_W-1:0] retry_cnt;
   logic             d_done;
   logic             req;
   logic             exhausted;

   assign req       = run && mem_access && !d_done && (d_state == D_IDLE);
   assign exhausted = (retry_cnt == CNT_W'(RETRY_MAX - 1));
   assign dmem_stb  = req;
   assign dmem_cyc  = req || (d_state == D_BACKOFF);
   assign d_ready   = !mem_access || dmem_resp || d_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_state   <= D_IDLE;
         retry_cnt <= '0;
         d_done    <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         case (d_state)
            D_IDLE: begin
               // A response in the same cycle as a retry wins.
               if (req && !dmem_resp && dmem_retry) begin
                  if (exhausted) begin
                     mem_err <= 1'b1;
                     d_done  <= 1'b1;
                  end else begin
                     d_state <= D_BACKOFF;
                  end
               end else if (req && dmem_resp && !advance) begin
                  d_done <= 1'b1;
               end
            end
            D_BACKOFF: begin
               retry_cnt <= retry_cnt + 1'b1;
               d_state   <= D_IDLE;
            end
            default: d_state <= D_IDLE;
         endcase
         if (advance) begin
            d_done    <= 1'b0;
            retry_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/pipeline_mem_ctrl.sv
// Pipeline/cache sequencer for the 5-stage lc3b: I-side fetch FSM, global
// advance/stall, branch squash and the stall-cycle counter.
//   state   | meaning
//   I_FETCH | strobing the I-cache for the next instruction
//   I_HELD  | instruction captured in the IR hold register, waiting to advance
module pipeline_mem_ctrl
   import pipeline_mem_ctrl_pkg::*;
#(
   parameter int RETRY_MAX   = RETRY_MAX_DEF,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_mem_ctrl_if.master    mem_bus,
   input  logic                   mem_access,
   input  logic                   branch_enable,
   output logic                   ir_capture,
   output logic                   ir_sel_held,
   output logic                   load_if_id,
   output logic                   load_id_ex,
   output logic                   load_ex_mem,
   output logic                   load_mem_wb,
   output logic                   flush_if_id,
   output logic                   flush_id_ex,
   output logic                   flush_ex_mem,
   output logic                   mem_err,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   lc3b_ifsm_t i_state;
   logic       run;
   logic       fetching;
   logic       i_ready;
   logic       d_ready;
   logic       advance;
   logic       flush;

   // run keeps every strobe low until the first edge after reset releases.
   assign fetching         = run && (i_state == I_FETCH);
   assign mem_bus.imem_stb = fetching;
   assign mem_bus.imem_cyc = fetching;
   assign ir_sel_held      = (i_state == I_HELD);
   assign i_ready          = (fetching && mem_bus.imem_resp) || ir_sel_held;
   assign advance          = i_ready && d_ready;
   assign ir_capture       = fetching && mem_bus.imem_resp && !advance;

   assign load_if_id  = advance;
   assign load_id_ex  = advance;
   assign load_ex_mem = advance;
   assign load_mem_wb = advance;

   // branch_enable is frozen in MEM/WB during a stall, so the squash lands
   // exactly on the advancing cycle.
   assign flush        = branch_enable && advance;
   assign flush_if_id  = flush;
   assign flush_id_ex  = flush;
   assign flush_ex_mem = flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run          <= 1'b0;
         i_state      <= I_FETCH;
         stall_cycles <= '0;
      end else begin
         run <= 1'b1;
         case (i_state)
            I_FETCH: if (ir_capture) i_state <= I_HELD;
            I_HELD:  if (advance)    i_state <= I_FETCH;
            default: i_state <= I_FETCH;
         endcase
         if (run && !advance && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

   pipeline_mem_ctrl_dmem_port_fsm #(
      .RETRY_MAX (RETRY_MAX)
   ) u_dmem_port_fsm (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .mem_access (mem_access),
      .dmem_resp  (mem_bus.dmem_resp),
      .dmem_retry (mem_bus.dmem_retry),
      .advance    (advance),
      .dmem_stb   (mem_bus.dmem_stb),
      .dmem_cyc   (mem_bus.dmem_cyc),
      .d_ready    (d_ready),
      .mem_err    (mem_err)
   );

endmodule
